mem_port_arbiter: RTL

Shares the single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipeline. A three-state FSM grants the port, drives the memory req/ready handshake, and returns read data to the requester. It raises a pipeline-wide `stall` until every access requested in the current pipeline cycle has completed. `stall` is ORed externally with the hazard-detection stall.

---
 rtl/mem_port_arbiter_pkg.sv | 12 +
 rtl/mem_wait_timer.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared arbiter definitions: FSM state encodings and the default timeout bound.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } arb_state_e;

    localparam int unsigned MAX_WAIT_DEFAULT = 15;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait timer for an outstanding memory request: loaded at grant, counts down while
// the request is unanswered, and flags expiry on the MAX_WAIT-th unanswered cycle.
module mem_wait_timer
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic active,
    input  logic ready,
    output logic expired
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // A terminal count of zero means this is the last cycle the request may wait.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = CW'(MAX_WAIT - 1);
        end else if (active && !ready && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    assign expired = active && !ready && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port memory between instruction fetch and the load/store stage,
// stalling the pipeline until every access of the current pipeline cycle completes.
//
// state | meaning
// IDLE  | no request outstanding; grants a pending data access first, then a fetch
// DATA  | load/store on the memory port, waiting for mem_ready or timeout
// FETCH | instruction fetch on the memory port, waiting for mem_ready or timeout
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned LEN_ADDR = 32,
    parameter int unsigned LEN_DATA = 32,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [LEN_ADDR-1:0] if_addr,
    output logic [LEN_DATA-1:0] if_rdata,
    output logic                if_done,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [LEN_ADDR-1:0] d_addr,
    input  logic [LEN_DATA-1:0] d_wdata,
    output logic [LEN_DATA-1:0] d_rdata,
    output logic                d_done,
    output logic                mem_req,
    output logic                mem_we,
    output logic [LEN_ADDR-1:0] mem_addr,
    output logic [LEN_DATA-1:0] mem_wdata,
    input  logic [LEN_DATA-1:0] mem_rdata,
    input  logic                mem_ready,
    output logic                stall,
    output logic                timeout_err
);

    arb_state_e          state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [LEN_ADDR-1:0] mem_addr_q, mem_addr_d;
    logic [LEN_DATA-1:0] mem_wdata_q, mem_wdata_d;
    logic [LEN_DATA-1:0] if_rdata_q, if_rdata_d;
    logic [LEN_DATA-1:0] d_rdata_q, d_rdata_d;
    logic                if_done_q, if_done_d;
    logic                d_done_q, d_done_d;
    logic                if_served_q, if_served_d;
    logic                d_served_q, d_served_d;
    logic                timeout_err_q, timeout_err_d;

    logic if_pend, d_pend;
    logic grant, expired, if_cmpl, d_cmpl;

    // The done pulse masks the request for the cycle before the served flag is seen.
    assign if_pend = if_req && !if_served_q && !if_done_q;
    assign d_pend  = (d_read || d_write) && !d_served_q && !d_done_q;
    assign stall   = if_pend || d_pend;

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (grant),
        .active  (mem_req_q),
        .ready   (mem_ready),
        .expired (expired)
    );

    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        if_rdata_d    = if_rdata_q;
        d_rdata_d     = d_rdata_q;
        if_done_d     = 1'b0;
        d_done_d      = 1'b0;
        timeout_err_d = timeout_err_q;
        grant         = 1'b0;
        if_cmpl       = 1'b0;
        d_cmpl        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (d_pend) begin
                    state_d     = DATA;
                    grant       = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_write;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (if_pend) begin
                    state_d    = FETCH;
                    grant      = 1'b1;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                end
            end
            DATA: begin
                if (mem_ready || expired) begin
                    d_cmpl    = 1'b1;
                    d_done_d  = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = IDLE;
                    if (!mem_we_q) begin
                        d_rdata_d = mem_ready ? mem_rdata : '0;
                    end
                    if (!mem_ready) begin
                        timeout_err_d = 1'b1;
                    end else if (if_pend) begin
                        state_d    = FETCH;
                        grant      = 1'b1;
                        mem_req_d  = 1'b1;
                        mem_addr_d = if_addr;
                    end
                end
            end
            FETCH: begin
                if (mem_ready || expired) begin
                    if_cmpl    = 1'b1;
                    if_done_d  = 1'b1;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    state_d    = IDLE;
                    if_rdata_d = mem_ready ? mem_rdata : '0;
                    if (!mem_ready) begin
                        timeout_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A pipeline advance starts a new cycle, so it wins over a completion (flush case).
    assign if_served_d = stall ? (if_served_q || if_cmpl) : 1'b0;
    assign d_served_d  = stall ? (d_served_q || d_cmpl) : 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            if_rdata_q    <= '0;
            d_rdata_q     <= '0;
            if_done_q     <= 1'b0;
            d_done_q      <= 1'b0;
            if_served_q   <= 1'b0;
            d_served_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            if_rdata_q    <= if_rdata_d;
            d_rdata_q     <= d_rdata_d;
            if_done_q     <= if_done_d;
            d_done_q      <= d_done_d;
            if_served_q   <= if_served_d;
            d_served_q    <= d_served_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign if_done     = if_done_q;
    assign d_done      = d_done_q;
    assign timeout_err = timeout_err_q;

endmodule
